uart_rx_ctrl: RTL and testbench

//  Receive-side UART controller: generates 16x oversample tick, qualifies start bit at mid-bit,

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encoding for the UART receiver.
// Imported by uart_rx_ctrl and uart_rx_fifo.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous byte FIFO for received data.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_BITS-1:0]     i_data,
  input  logic                     i_pop,
  output logic [DATA_BITS-1:0]     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [AW:0]          r_cnt;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_cnt == FULL_CNT);
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // storage write; contents need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x oversampled UART receiver with output byte FIFO.
// Optional even parity bit enabled by defining UART_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 54,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [3:0]    S_MID     = 4'(MID_SAMPLE);
  localparam logic [3:0]    S_LAST    = 4'(OVERSAMPLE - 1);

  logic [1:0]           r_sync;
  logic                 r_rx_prev;
  logic [TW-1:0]        r_tcnt;
  rx_state_e            r_state;
  rx_state_e            w_state_nx;
  logic [3:0]           r_s;
  logic [3:0]           w_s_nx;
  logic [2:0]           r_bit;
  logic [2:0]           w_bit_nx;
  logic [7:0]           r_shift;
  logic [7:0]           w_shift_nx;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_rx;
  logic                 w_fall;
  logic                 w_tick;
  logic                 w_start;
  logic                 w_push;
  logic                 w_ferr;
  logic                 w_par_bad;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_fifo_data;

  assign w_rx    = r_sync[1];
  assign w_fall  = r_rx_prev & ~w_rx;
  assign w_tick  = (r_tcnt == TICK_LAST);
  assign w_start = (r_state == S_IDLE) & w_fall;
  assign w_pop   = dout_valid & dout_ready;

`ifdef UART_PARITY_EN
  logic r_par_err;
  logic w_par_nx;
  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  // two-stage synchroniser plus edge history, preset high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_prev <= r_sync[1];
    end
  end

  // free-running oversample divider, realigned on start edge
  always_ff @(posedge clk) begin
    if (rst)           r_tcnt <= '0;
    else if (w_start)  r_tcnt <= '0;
    else if (w_tick)   r_tcnt <= '0;
    else               r_tcnt <= r_tcnt + 1'b1;
  end

  // next-state and bit sampling decisions
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_push     = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_PARITY_EN
    w_par_nx   = r_par_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nx = S_START;
          w_s_nx     = '0;
`ifdef UART_PARITY_EN
          w_par_nx   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_s == S_MID) begin
            w_s_nx   = '0;
            w_bit_nx = '0;
            w_state_nx = w_rx ? S_IDLE : S_DATA;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx     = '0;
            w_shift_nx = {w_rx, r_shift[7:1]};
            w_bit_nx   = r_bit + 1'b1;
            if (r_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              w_state_nx = S_PARITY;
`else
              w_state_nx = S_STOP;
`endif
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx     = '0;
            w_par_nx   = ^{r_shift, w_rx};
            w_state_nx = S_STOP;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_s == S_LAST) begin
            w_s_nx     = '0;
            w_state_nx = S_IDLE;
            if (w_rx && !w_par_bad) w_push = 1'b1;
            else                    w_ferr = 1'b1;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM and datapath registers, error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_s         <= w_s_nx;
      r_bit       <= w_bit_nx;
      r_shift     <= w_shift_nx;
      r_frame_err <= w_ferr;
      r_overrun   <= w_push & w_full & ~w_pop;
    end
  end

`ifdef UART_PARITY_EN
  // parity verdict held until the stop-bit decision
  always_ff @(posedge clk) begin
    if (rst) r_par_err <= 1'b0;
    else     r_par_err <= w_par_nx;
  end
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign dout       = w_empty ? 8'h00 : w_fifo_data;
  assign dout_valid = ~w_empty;
  assign rx_busy    = (r_state != S_IDLE);
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl, CLK_DIV=4 (64 clk/bit).
// Frames are driven bit-by-bit; pops, pulses and valid cycles are logged.
module tb_uart_rx_ctrl;

  localparam int BIT = 64;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_log [64];
  int rx_n   = 0;
  int ferr_n = 0;
  int ovr_n  = 0;
  int vld_n  = 0;
  int k_lat  = 0;

  uart_rx_ctrl #(
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    if (dout_valid && dout_ready) begin
      rx_log[rx_n[5:0]] = dout;
      rx_n = rx_n + 1;
    end
    if (frame_err)  ferr_n = ferr_n + 1;
    if (overrun)    ovr_n  = ovr_n + 1;
    if (dout_valid) vld_n  = vld_n + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stopb);
    rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(BIT);
    end
    rx = stopb;
    clks(BIT);
    rx = 1'b1;
    clks(16);
  endtask

  task automatic drain4(input string tag, input logic [31:0] exp);
    int n0;
    n0 = rx_n;
    dout_ready = 1'b1;
    clks(8);
    dout_ready = 1'b0;
    clks(2);
    chk({tag, "_n"}, rx_n - n0, 4);
    for (int i = 0; i < 4; i++)
      chk({tag, "_b"}, int'(rx_log[(n0 + i) % 64]), int'(exp[8*i +: 8]));
  endtask

  int f0, o0, v0, n0;

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    dout_ready = 1'b0;
    clks(5);
    rst = 1'b0;
    clks(2);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_busy",  int'(rx_busy), 0);
    chk("rst_ferr",  int'(frame_err), 0);
    chk("rst_ovr",   int'(overrun), 0);

    // 0xA5 8N1, consumer ready
    dout_ready = 1'b1;
    clks(20);
    f0 = ferr_n; o0 = ovr_n; v0 = vld_n; n0 = rx_n;
    fork
      send(8'hA5, 1'b1);
      begin
        k_lat = 0;
        while (!dout_valid && k_lat < 2000) begin
          clks(1);
          k_lat++;
        end
      end
    join
    clks(20);
    chk("a5_lat_lo", int'(k_lat > 9 * BIT), 1);
    chk("a5_lat_hi", int'(k_lat <= 10 * BIT), 1);
    chk("a5_n",    rx_n - n0, 1);
    chk("a5_byte", int'(rx_log[n0 % 64]), 8'hA5);
    chk("a5_vld",  vld_n - v0, 1);
    chk("a5_ferr", ferr_n - f0, 0);
    chk("a5_ovr",  ovr_n - o0, 0);

    // 20-clk glitch on the line
    f0 = ferr_n; v0 = vld_n;
    rx = 1'b0;
    clks(10);
    chk("gl_busy1", int'(rx_busy), 1);
    clks(10);
    rx = 1'b1;
    clks(100);
    chk("gl_busy0", int'(rx_busy), 0);
    chk("gl_vld",   vld_n - v0, 0);
    chk("gl_ferr",  ferr_n - f0, 0);

    // 0x3C with bad stop bit
    f0 = ferr_n; o0 = ovr_n; v0 = vld_n;
    send(8'h3C, 1'b0);
    clks(20);
    chk("fe_ferr",  ferr_n - f0, 1);
    chk("fe_count", int'(fifo_count), 0);
    chk("fe_vld",   vld_n - v0, 0);
    chk("fe_ovr",   ovr_n - o0, 0);

    // fill FIFO and overrun on the fifth byte
    dout_ready = 1'b0;
    f0 = ferr_n; o0 = ovr_n;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    chk("ov_cnt4", int'(fifo_count), 4);
    chk("ov_none", ovr_n - o0, 0);
    send(8'h05, 1'b1);
    chk("ov_pulse", ovr_n - o0, 1);
    chk("ov_cnt",   int'(fifo_count), 4);
    chk("ov_ferr",  ferr_n - f0, 0);
    drain4("ov_drain", 32'h04030201);
    chk("ov_empty", int'(fifo_count), 0);

    // full FIFO, pop exactly on the fifth push
    o0 = ovr_n;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    fork
      send(8'h05, 1'b1);
      begin
        clks(k_lat - 1);
        dout_ready = 1'b1;
        clks(1);
        dout_ready = 1'b0;
      end
    join
    clks(4);
    chk("pp_ovr", ovr_n - o0, 0);
    chk("pp_cnt", int'(fifo_count), 4);
    drain4("pp_drain", 32'h05040302);

    // reset in the middle of 0xFF with a byte pending
    send(8'h77, 1'b1);
    chk("rs_pend", int'(fifo_count), 1);
    f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    clks(BIT);
    rx = 1'b1;
    clks(3 * BIT);
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(1);
    chk("rs_busy",  int'(rx_busy), 0);
    chk("rs_count", int'(fifo_count), 0);
    clks(6 * BIT);
    n0 = rx_n;
    dout_ready = 1'b1;
    send(8'h55, 1'b1);
    clks(20);
    chk("rs_n",    rx_n - n0, 1);
    chk("rs_byte", int'(rx_log[n0 % 64]), 8'h55);
    chk("rs_ferr", ferr_n - f0, 0);
    chk("rs_ovr",  ovr_n - o0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
